// File: rtl/hwag_cfg_seq.sv
// hwag_cfg_seq: loads a block of configuration words from a valid/ready
// source into a synchronous SRAM, one word per write strobe.
// Optional read-back verify is enabled by defining HWAG_CFG_VERIFY_EN:
// each written word is read back and compared, and the first mismatch
// stops the sequence and is reported through err/err_addr.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// FETCH  | src_ready high, waiting for a source word
// WRITE  | ssram_we high for the latched word at the current address
// READ   | (verify only) ssram_re high at the address just written
// CHECK  | (verify only) compare read data, advance or flag an error
// DONE   | one-cycle done pulse, then back to IDLE
module hwag_cfg_seq #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              ssram_we,
    output logic              ssram_re,
    output logic [ADDR_W-1:0] ssram_addr,
    output logic [DATA_W-1:0] ssram_wdata,
    input  logic [DATA_W-1:0] ssram_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
`ifdef HWAG_CFG_VERIFY_EN
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_CHECK = 3'd5;
`endif

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic [ADDR_W-1:0] r_ssram_addr;
    logic [DATA_W-1:0] r_ssram_wdata;
    logic              w_last;
    logic              w_accept;
    logic              w_take;
    logic              w_advance;

    assign w_last   = (r_remaining == ADDR_W'(1));
    assign w_accept = (r_state == S_IDLE) && start && !abort;
    assign w_take   = (r_state == S_FETCH) && src_valid && !abort;

`ifdef HWAG_CFG_VERIFY_EN
    logic              w_match;
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;

    assign w_match   = (ssram_rdata == r_ssram_wdata);
    assign w_advance = (r_state == S_CHECK) && w_match && !abort;
    assign ssram_re  = (r_state == S_READ);
    assign err       = r_err;
    assign err_addr  = r_err_addr;
`else
    logic w_unused_rdata;

    assign w_unused_rdata = ^ssram_rdata;
    assign w_advance      = (r_state == S_WRITE) && !abort;
    assign ssram_re       = 1'b0;
    assign err            = 1'b0;
    assign err_addr       = '0;
`endif

    assign src_ready   = (r_state == S_FETCH);
    assign ssram_we    = (r_state == S_WRITE);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign ssram_addr  = r_ssram_addr;
    assign ssram_wdata = r_ssram_wdata;

    // Next-state decode; abort overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = (count == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (src_valid) w_next_state = S_WRITE;
`ifdef HWAG_CFG_VERIFY_EN
            S_WRITE: w_next_state = S_READ;
            S_READ:  w_next_state = S_CHECK;
            S_CHECK: w_next_state = (!w_match || w_last) ? S_DONE : S_FETCH;
`else
            S_WRITE: w_next_state = w_last ? S_DONE : S_FETCH;
`endif
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (abort) w_next_state = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Address and remaining-word counters: loaded on start, stepped per word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if (w_accept) begin
            r_addr      <= base_addr;
            r_remaining <= count;
        end else if (w_advance) begin
            r_addr      <= r_addr + ADDR_W'(1);
            r_remaining <= r_remaining - ADDR_W'(1);
        end
    end

    // SRAM address/data only change when a new word is taken, so they hold between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ssram_addr  <= '0;
            r_ssram_wdata <= '0;
        end else if (w_take) begin
            r_ssram_addr  <= r_addr;
            r_ssram_wdata <= src_data;
        end
    end

`ifdef HWAG_CFG_VERIFY_EN
    // Sticky error: cleared by an accepted start, set on the first read-back mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_accept) begin
            r_err      <= 1'b0;
        end else if ((r_state == S_CHECK) && !w_match && !abort) begin
            r_err      <= 1'b1;
            r_err_addr <= r_ssram_addr;
        end
    end
`endif

endmodule

// File: tb/tb_hwag_cfg_seq.sv
// Testbench for hwag_cfg_seq; also builds with HWAG_CFG_VERIFY_EN defined.
module tb_hwag_cfg_seq;

`ifdef HWAG_CFG_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int COST     = VERIFY ? 4 : 2;
    localparam int DONE_LAG = VERIFY ? 3 : 1;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  base_addr;
    logic [7:0]  count;
    logic [15:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic        ssram_we;
    logic        ssram_re;
    logic [7:0]  ssram_addr;
    logic [15:0] ssram_wdata;
    logic [15:0] ssram_rdata = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  err_addr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] src_words[$];
    int          wr_cyc[$];
    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];
    int          rd_cyc[$];
    logic [7:0]  rd_addr[$];
    int          done_cyc[$];
    int          both_cnt = 0;
    bit          busy_hist[int];
    bit          ready_hist[int];
    logic [15:0] mem[256];
    int          corrupt_addr = -1;
    logic [15:0] corrupt_val  = '0;

    hwag_cfg_seq #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .count(count),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .ssram_we(ssram_we), .ssram_re(ssram_re), .ssram_addr(ssram_addr),
        .ssram_wdata(ssram_wdata), .ssram_rdata(ssram_rdata),
        .busy(busy), .done(done), .err(err), .err_addr(err_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor and SRAM model: read data appears the cycle after the read strobe.
    always @(negedge clk) begin
        busy_hist[cyc]  = busy;
        ready_hist[cyc] = src_ready;
        if (ssram_we) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(ssram_addr);
            wr_data.push_back(ssram_wdata);
            mem[ssram_addr] = ssram_wdata;
        end
        if (ssram_re) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(ssram_addr);
            ssram_rdata = (int'(ssram_addr) == corrupt_addr) ? corrupt_val : mem[ssram_addr];
        end
        if (done) done_cyc.push_back(cyc);
        if (ssram_we && ssram_re) both_cnt++;
    end

    // Runs one load sequence. kill_kind: 0 none, 1 abort, 2 reset, 3 extra start (must be ignored);
    // the kill fires in the FETCH cycle of word kill_idx. The stall holds src_valid low for
    // stall_len FETCH cycles of word stall_idx.
    task automatic run_load(input logic [7:0] base, input logic [7:0] cnt,
                            input int stall_idx, input int stall_len,
                            input int kill_idx, input int kill_kind,
                            output int start_c, output int kill_c, output bit timed_out);
        int idx = 0;
        int left = stall_len;
        int n = 0;
        int end_c = -1;
        bit fin = 0;
        bit killed = 0;
        bit fired = 0;
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        rd_cyc.delete(); rd_addr.delete(); done_cyc.delete();
        kill_c = -1;
        timed_out = 0;
        @(posedge clk); #1;
        base_addr = base; count = cnt; start = 1; abort = 0; rst = 0;
        src_valid = 0; src_data = 16'($urandom);
        @(negedge clk);
        start_c = cyc;
        while (!fin) begin
            @(posedge clk); #1;
            start = 0; abort = 0; rst = 0;
            base_addr = 8'($urandom); count = 8'($urandom);
            src_valid = 0; src_data = 16'($urandom);
            if (idx < src_words.size() && !killed) begin
                if (idx == stall_idx && left > 0) begin
                    if (src_ready) left--;
                end else begin
                    src_valid = 1; src_data = src_words[idx];
                end
            end
            if (!fired && kill_kind != 0 && idx == kill_idx && src_ready) begin
                fired = 1;
                kill_c = cyc;
                case (kill_kind)
                    1: begin abort = 1; killed = 1; end
                    2: begin rst = 1; killed = 1; end
                    default: start = 1;
                endcase
            end
            @(negedge clk);
            if (src_ready && src_valid && !abort && !rst) idx++;
            if (end_c < 0 && (done || killed)) end_c = cyc;
            if (end_c >= 0 && cyc >= end_c + 4) fin = 1;
            n++;
            if (n > 400) begin timed_out = 1; fin = 1; end
        end
        start = 0; abort = 0; rst = 0; src_valid = 0;
    endtask

    task automatic test_reset();
        rst = 1; start = 1; src_valid = 1; abort = 0;
        base_addr = 8'h5A; count = 8'h03; src_data = 16'hBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (src_ready !== 1'b0) begin failures++; $display("FAIL reset_src_ready got %b want 0", src_ready); end
        checks++; if (ssram_we !== 1'b0 || ssram_re !== 1'b0) begin failures++; $display("FAIL reset_strobes got we=%b re=%b want 0", ssram_we, ssram_re); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (ssram_addr !== 8'h00 || ssram_wdata !== 16'h0000 || err_addr !== 8'h00) begin
            failures++; $display("FAIL reset_regs got addr=%h wdata=%h err_addr=%h want 0", ssram_addr, ssram_wdata, err_addr); end
        @(posedge clk); #1;
        rst = 0; start = 0; src_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_no_start got busy=%b want 0", busy); end
    endtask

    // Fixed six-word load from address 0 plus a three-word load that wraps the address.
    task automatic test_directed();
        int c, k;
        bit to;
        logic [15:0] w[6] = '{16'd128, 16'd0, 16'd1024, 16'd0, 16'd57, 16'd4};
        src_words.delete();
        foreach (w[i]) src_words.push_back(w[i]);
        run_load(8'd0, 8'd6, -1, 0, -1, 0, c, k, to);
        checks++; if (to) begin failures++; $display("FAIL dir_timeout got timeout want done"); end
        checks++; if (wr_addr.size() != 6) begin failures++; $display("FAIL dir_wr_count got %0d want 6", wr_addr.size()); end
        for (int i = 0; i < 6 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== 8'(i) || wr_data[i] !== w[i] || wr_cyc[i] != c + COST*i + 2) begin
                failures++;
                $display("FAIL dir_write[%0d] got a=%0d d=%0d t=%0d want a=%0d d=%0d t=%0d",
                         i, wr_addr[i], wr_data[i], wr_cyc[i] - c, i, w[i], COST*i + 2);
            end
        end
        checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL dir_done_count got %0d want 1", done_cyc.size()); end
        if (done_cyc.size() > 0) begin
            checks++; if (done_cyc[0] != c + COST*6 + 1) begin failures++; $display("FAIL dir_done_time got %0d want %0d", done_cyc[0] - c, COST*6 + 1); end
            checks++; if (busy_hist[done_cyc[0]] !== 1'b1 || busy_hist[done_cyc[0] + 1] !== 1'b0) begin
                failures++; $display("FAIL dir_busy_after got %b%b want 10", busy_hist[done_cyc[0]], busy_hist[done_cyc[0] + 1]); end
        end

        src_words.delete();
        for (int i = 0; i < 3; i++) src_words.push_back(16'($urandom));
        run_load(8'd254, 8'd3, -1, 0, -1, 0, c, k, to);
        checks++; if (to || wr_addr.size() != 3) begin failures++; $display("FAIL wrap_count got %0d want 3", wr_addr.size()); end
        for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== 8'((254 + i) % 256) || wr_data[i] !== src_words[i]) begin
                failures++; $display("FAIL wrap_write[%0d] got a=%0d d=%h want a=%0d d=%h",
                                     i, wr_addr[i], wr_data[i], (254 + i) % 256, src_words[i]);
            end
        end
    endtask

    task automatic test_zero_count();
        int c, k;
        bit to;
        src_words.delete();
        run_load(8'($urandom), 8'd0, -1, 0, -1, 0, c, k, to);
        checks++; if (to || done_cyc.size() != 1) begin failures++; $display("FAIL zero_done_count got %0d want 1", done_cyc.size()); end
        if (done_cyc.size() > 0) begin
            checks++; if (done_cyc[0] != c + 1) begin failures++; $display("FAIL zero_done_time got %0d want 1", done_cyc[0] - c); end
        end
        checks++; if (wr_addr.size() != 0 || rd_addr.size() != 0) begin
            failures++; $display("FAIL zero_strobes got wr=%0d rd=%0d want 0", wr_addr.size(), rd_addr.size()); end
        checks++; if (busy_hist[c + 2] !== 1'b0) begin failures++; $display("FAIL zero_busy_after got %b want 0", busy_hist[c + 2]); end
    endtask

    task automatic test_stall();
        int c, k, s0;
        int bad = 0;
        bit to;
        src_words.delete();
        for (int i = 0; i < 4; i++) src_words.push_back(16'($urandom));
        run_load(8'd40, 8'd4, 1, 10, -1, 0, c, k, to);
        s0 = c + COST + 1;
        for (int t = s0; t < s0 + 10; t++) if (ready_hist[t] !== 1'b1) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL stall_ready got %0d low cycles want 0", bad); end
        bad = 0;
        foreach (wr_cyc[i]) if (wr_cyc[i] >= s0 && wr_cyc[i] <= s0 + 10) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL stall_strobe got %0d writes in stall want 0", bad); end
        checks++; if (to || wr_addr.size() != 4) begin failures++; $display("FAIL stall_count got %0d want 4", wr_addr.size()); end
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== 8'(40 + i) || wr_data[i] !== src_words[i] ||
                wr_cyc[i] != c + COST*i + 2 + (i >= 1 ? 10 : 0)) begin
                failures++; $display("FAIL stall_write[%0d] got a=%0d t=%0d want a=%0d t=%0d",
                                     i, wr_addr[i], wr_cyc[i] - c, 40 + i, COST*i + 2 + (i >= 1 ? 10 : 0));
            end
        end
    endtask

    // Random bases, lengths, data and stalls, some with an ignored extra start mid-sequence.
    task automatic test_random();
        int c, k, n, last;
        bit to;
        logic [7:0] base;
        for (int it = 0; it < 8; it++) begin
            base = 8'($urandom);
            n = $urandom_range(1, 12);
            src_words.delete();
            for (int i = 0; i < n; i++) src_words.push_back(16'($urandom));
            run_load(base, 8'(n), $urandom_range(0, n - 1), $urandom_range(0, 5),
                     (it % 2 == 1) ? 1 : -1, (it % 2 == 1) ? 3 : 0, c, k, to);
            checks++; if (to || wr_addr.size() != n) begin failures++; $display("FAIL rnd%0d_count got %0d want %0d", it, wr_addr.size(), n); end
            for (int i = 0; i < n && i < wr_addr.size(); i++) begin
                checks++;
                if (wr_addr[i] !== 8'((int'(base) + i) % 256) || wr_data[i] !== src_words[i]) begin
                    failures++; $display("FAIL rnd%0d_write[%0d] got a=%0d d=%h want a=%0d d=%h",
                                         it, i, wr_addr[i], wr_data[i], (int'(base) + i) % 256, src_words[i]);
                end
            end
            if (VERIFY) begin
                checks++; if (rd_addr.size() != wr_addr.size()) begin failures++; $display("FAIL rnd%0d_reads got %0d want %0d", it, rd_addr.size(), wr_addr.size()); end
                for (int i = 0; i < rd_addr.size() && i < wr_addr.size(); i++) begin
                    checks++;
                    if (rd_addr[i] !== wr_addr[i] || rd_cyc[i] != wr_cyc[i] + 1) begin
                        failures++; $display("FAIL rnd%0d_read[%0d] got a=%0d want a=%0d", it, i, rd_addr[i], wr_addr[i]);
                    end
                end
                checks++; if (err !== 1'b0) begin failures++; $display("FAIL rnd%0d_err got %b want 0", it, err); end
            end
            checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL rnd%0d_done_count got %0d want 1", it, done_cyc.size()); end
            if (done_cyc.size() > 0 && wr_cyc.size() > 0) begin
                last = wr_cyc[wr_cyc.size() - 1];
                checks++; if (done_cyc[0] != last + DONE_LAG) begin failures++; $display("FAIL rnd%0d_done_time got %0d want %0d", it, done_cyc[0] - last, DONE_LAG); end
            end
            checks++;
            if (ssram_addr !== 8'((int'(base) + n - 1) % 256) || ssram_wdata !== src_words[n - 1]) begin
                failures++; $display("FAIL rnd%0d_hold got a=%0d d=%h want a=%0d d=%h",
                                     it, ssram_addr, ssram_wdata, (int'(base) + n - 1) % 256, src_words[n - 1]);
            end
        end
    endtask

    task automatic test_abort();
        int c, k, late = 0;
        bit to;
        src_words.delete();
        for (int i = 0; i < 6; i++) src_words.push_back(16'($urandom));
        run_load(8'd100, 8'd6, -1, 0, 2, 1, c, k, to);
        checks++; if (to || k != c + COST*2 + 1) begin failures++; $display("FAIL abort_fired got %0d want %0d", k - c, COST*2 + 1); end
        checks++; if (wr_addr.size() != 2) begin failures++; $display("FAIL abort_wr_count got %0d want 2", wr_addr.size()); end
        foreach (wr_cyc[i]) if (wr_cyc[i] > k) late++;
        foreach (rd_cyc[i]) if (rd_cyc[i] > k) late++;
        checks++; if (late != 0) begin failures++; $display("FAIL abort_late_strobes got %0d want 0", late); end
        checks++; if (done_cyc.size() != 0) begin failures++; $display("FAIL abort_done got %0d want 0", done_cyc.size()); end
        checks++; if (busy_hist[k + 1] !== 1'b0) begin failures++; $display("FAIL abort_busy got %b want 0", busy_hist[k + 1]); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL abort_err got %b want 0", err); end
    endtask

    task automatic test_rst_mid();
        int c, k, late = 0;
        bit to;
        src_words.delete();
        for (int i = 0; i < 6; i++) src_words.push_back(16'($urandom));
        run_load(8'd10, 8'd6, -1, 0, 3, 2, c, k, to);
        checks++; if (to || wr_addr.size() != 3) begin failures++; $display("FAIL rst_wr_count got %0d want 3", wr_addr.size()); end
        foreach (wr_cyc[i]) if (wr_cyc[i] > k) late++;
        foreach (rd_cyc[i]) if (rd_cyc[i] > k) late++;
        checks++; if (late != 0) begin failures++; $display("FAIL rst_late_strobes got %0d want 0", late); end
        checks++; if (done_cyc.size() != 0) begin failures++; $display("FAIL rst_done got %0d want 0", done_cyc.size()); end
        checks++; if (busy_hist[k + 1] !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", busy_hist[k + 1]); end
        checks++; if (ssram_addr !== 8'h00 || ssram_wdata !== 16'h0000) begin
            failures++; $display("FAIL rst_regs got a=%h d=%h want 0", ssram_addr, ssram_wdata); end
    endtask

`ifdef HWAG_CFG_VERIFY_EN
    task automatic test_verify_mismatch();
        int c, k;
        bit to;
        src_words.delete();
        src_words.push_back(16'h1111); src_words.push_back(16'h2222); src_words.push_back(16'h0003);
        src_words.push_back(16'h4444); src_words.push_back(16'h5555);
        corrupt_addr = 64;
        corrupt_val  = 16'h0007;
        run_load(8'd62, 8'd5, -1, 0, -1, 0, c, k, to);
        corrupt_addr = -1;
        checks++; if (to || wr_addr.size() != 3) begin failures++; $display("FAIL ver_wr_count got %0d want 3", wr_addr.size()); end
        if (wr_addr.size() == 3) begin
            checks++; if (wr_addr[2] !== 8'd64 || wr_data[2] !== 16'h0003) begin
                failures++; $display("FAIL ver_write got a=%0d d=%h want a=64 d=0003", wr_addr[2], wr_data[2]); end
        end
        checks++; if (err !== 1'b1 || err_addr !== 8'd64) begin
            failures++; $display("FAIL ver_err got err=%b addr=%0d want err=1 addr=64", err, err_addr); end
        checks++; if (done_cyc.size() != 1) begin failures++; $display("FAIL ver_done got %0d want 1", done_cyc.size()); end
        if (done_cyc.size() == 1 && wr_cyc.size() > 0) begin
            checks++; if (done_cyc[0] != wr_cyc[wr_cyc.size() - 1] + 3) begin
                failures++; $display("FAIL ver_done_time got %0d want 3", done_cyc[0] - wr_cyc[wr_cyc.size() - 1]); end
        end
        src_words.delete();
        src_words.push_back(16'h0ABC);
        run_load(8'd5, 8'd1, -1, 0, -1, 0, c, k, to);
        checks++; if (to || err !== 1'b0 || err_addr !== 8'd64) begin
            failures++; $display("FAIL ver_err_clear got err=%b addr=%0d want err=0 addr=64", err, err_addr); end
    endtask
`endif

    task automatic test_exclusive();
        checks++; if (both_cnt != 0) begin failures++; $display("FAIL strobe_overlap got %0d cycles want 0", both_cnt); end
    endtask

    initial begin
        rst = 1; start = 0; abort = 0; base_addr = '0; count = '0;
        src_data = '0; src_valid = 0;
        test_reset();
        test_directed();
        test_zero_count();
        test_stall();
        test_random();
        test_abort();
        test_rst_mid();
`ifdef HWAG_CFG_VERIFY_EN
        test_verify_mismatch();
`endif
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
